dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer that shares the single-port data memory (`d_mem`) between the processor load/store path (port 0) and a DMA/debug master (port 1). It grants one requester at a time and latches that requester's command. It then drives the memory's address/writeData/memWrite/memRead for exactly one cycle and returns read data with a one-cycle acknowledge. It sits between the processor's MEM stage / DMA engine and `d_mem`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req0` input 1: port 0 request; held high until `ack0`.
- `we0` input 1: port 0 write (1) or read (0); stable while `req0` is high.
- `addr0` input ADDR_W: port 0 address.
- `wdata0` input DATA_W: port 0 write data.
- `ack0` output 1: one-cycle completion pulse for port 0.
- `rdata0` output DATA_W: port 0 read data; valid while `ack0` is high, held afterwards.
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`, `rdata1`: same definitions for port 1.
- `memAddress` output ADDR_W: memory address.
- `memWriteData` output DATA_W: memory write data.
- `memWrite` output 1: memory write strobe.
- `memRead` output 1: memory read strobe.
- `memReadData` input DATA_W: memory read data, combinational from `memAddress` when `memRead` is high.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - With no request pending, the FSM stays in IDLE.
  - With any request pending, it arbitrates, latches the winner's `we`/`addr`/`wdata` and port id (`gnt`), then moves to ACCESS.
- **ACCESS**
  - Drives `memAddress` and `memWriteData` from the latched command.
  - Asserts exactly one of `memWrite` (latched `we`=1) or `memRead` (latched `we`=0) for this one cycle.
  - On a read, captures `memReadData` into the granted port's `rdata` register at the end of the cycle.
  - Moves to RESP.
- **RESP**
  - Asserts the granted port's `ack` for one cycle; the other port's `ack` stays 0.
  - Moves to IDLE.
- **Arbitration** is round-robin using a `last` pointer.
  - When both requests are pending, the port not equal to `last` wins.
  - When one request is pending, that port wins.
  - `last` is updated to the winner at grant time.
- `req` inputs are sampled only in IDLE. Requests that arrive or drop during ACCESS/RESP have no effect on the transfer in progress.
- A requester that keeps `req` high after its `ack` is treated as a new request in the following IDLE cycle.
- Outputs outside ACCESS:
  - `memWrite` and `memRead` are 0.
  - `memAddress` and `memWriteData` hold their last driven values.
- `memWrite` and `memRead` are never high together.
- `rdataN` changes only on a read completion for port N. Writes leave `rdataN` unchanged.

## Timing
- Reset values (`rst_n`=0, asynchronous):
  - FSM state is IDLE.
  - `last`=1, so port 0 wins the first tie.
  - `ack0`=`ack1`=0, `memWrite`=`memRead`=0.
  - `memAddress`=0, `memWriteData`=0, `rdata0`=`rdata1`=0.
  - All latched command registers are 0.
- Reset asserted mid-transfer (ACCESS or RESP):
  - The strobe and `ack` drop immediately, without waiting for a clock edge.
  - The transfer is abandoned with no `ack`.
  - The requester re-requests after reset.
- Latency:
  - Request high in IDLE at edge t produces ACCESS in cycle t+1 and `ack` in cycle t+2.
  - IDLE resumes in cycle t+3.
- Throughput is one access per 3 cycles. With both ports continuously requesting, grants alternate 0,1,0,1…
- Worst-case wait for a requester is one other port's transfer (3 cycles) plus its own 3 cycles.

## Configuration
- Macro `DMEM_ARB_FIXED_PRIO_EN`:
  - **Defined:** fixed priority; port 0 always wins a tie. The `last` pointer is not implemented. Port 1 can starve under continuous port 0 traffic.
  - **Undefined (default):** round-robin as described under Operation.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ACCESS of a write to 0x10 → `memWrite` drops to 0 the same cycle; no `ack`; all outputs take their reset values.
- **Port 0 write then read:** write 0xDEADBEEF to 0x4, then read 0x4 → `memWrite`=1 for exactly one cycle with `memAddress`=0x4; `ack0` two cycles after the request; `rdata0`=0xDEADBEEF on the read `ack0`; `ack1` stays 0.
- **Simultaneous first requests:** both ports read (port 0 at 0x8, port 1 at 0xC) right after reset → port 0 is served first (`ack0` at t+2), then port 1 (`ack1` at t+5); each `rdata` matches its own address.
- **Continuous contention:** both `req` held high for 12 cycles → `ack` pattern 0,1,0,1, one every 3 cycles. With `DMEM_ARB_FIXED_PRIO_EN` defined → `ack0` only.
- **Write does not disturb rdata:** port 1 reads 0x20 (0x12345678), then writes 0x99 to 0x24 → `rdata1` stays 0x12345678 after the write `ack1`.
- **Late request:** `req1` rises during port 0's ACCESS cycle → port 1 is not granted until the next IDLE; `ack1` arrives exactly 3 cycles after `ack0`.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port d_mem bus around dmem_arbiter.
// The arbiter connects through the slave modport; requesters and memory sit on the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memWrite;
    logic              memRead;
    logic [DATA_W-1:0] memReadData;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  memReadData,
        output ack0, rdata0, ack1, rdata1,
        output memAddress, memWriteData, memWrite, memRead
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output memReadData,
        input  ack0, rdata0, ack1, rdata1,
        input  memAddress, memWriteData, memWrite, memRead
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory: IDLE -> ACCESS -> RESP.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant;
    logic              win;
    logic              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_q;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    win = !bus.req0;
`else
                    win = (bus.req0 && bus.req1) ? !last_q : bus.req1;
`endif
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_q   <= win;
                we_q    <= win ? bus.we1    : bus.we0;
                addr_q  <= win ? bus.addr1  : bus.addr0;
                wdata_q <= win ? bus.wdata1 : bus.wdata0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                last_q  <= win;
`endif
            end
            // Read data is captured at the end of ACCESS into the granted port only.
            if (state_q == ACCESS && !we_q) begin
                if (gnt_q) rdata1_q <= bus.memReadData;
                else       rdata0_q <= bus.memReadData;
            end
        end
    end

    // Address/data follow the latched command, which only changes on entry to ACCESS,
    // so the bus holds its last driven values in IDLE and RESP.
    assign bus.memAddress   = addr_q;
    assign bus.memWriteData = wdata_q;
    assign bus.memWrite     = (state_q == ACCESS) &&  we_q;
    assign bus.memRead      = (state_q == ACCESS) && !we_q;

    assign bus.ack0   = (state_q == RESP) && !gnt_q;
    assign bus.ack1   = (state_q == RESP) &&  gnt_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single transfers plus reset, tie, contention and late-request sequences.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: combinational read, write at the end of the write strobe cycle.
    logic [DW-1:0] mem [0:63];
    always_comb bus.memReadData = mem[bus.memAddress[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
        forever begin
            @(posedge clk);
            if (bus.memWrite) mem[bus.memAddress[7:2]] <= bus.memWriteData;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    // Advance one clock and compare the handshake/strobe outputs just after the edge.
    task automatic step_check(input string tag, input bit e_ack0, input bit e_ack1,
                              input bit e_rd, input bit e_wr);
        @(posedge clk);
        #1;
        check({tag, " ack0"},     64'(bus.ack0),     64'(e_ack0));
        check({tag, " ack1"},     64'(bus.ack1),     64'(e_ack1));
        check({tag, " memRead"},  64'(bus.memRead),  64'(e_rd));
        check({tag, " memWrite"}, 64'(bus.memWrite), 64'(e_wr));
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;  // port's rdata expected on its ack (held value for writes)
    } vec_t;

    vec_t vecs [8];

    task automatic run_xfer(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        step_check({tag, " access"}, 1'b0, 1'b0, !v.we, v.we);
        check({tag, " memAddress"}, 64'(bus.memAddress), 64'(v.addr));
        if (v.we) check({tag, " memWriteData"}, 64'(bus.memWriteData), 64'(v.wdata));
        step_check({tag, " resp"}, !v.port, v.port, 1'b0, 1'b0);
        check({tag, " rdata"}, 64'(v.port ? bus.rdata1 : bus.rdata0), 64'(v.exp_rdata));
        set_port(v.port, 1'b0, 1'b0, '0, '0);
        step_check({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h04, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'h24, 32'h99,       32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'h24, 32'h0,        32'h99};
        vecs[6] = '{1'b0, 1'b1, 32'h04, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 1'b0, 32'h24, 32'h0,        32'h99};

        rst_n = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset ack0",         64'(bus.ack0),         64'd0);
        check("reset ack1",         64'(bus.ack1),         64'd0);
        check("reset memWrite",     64'(bus.memWrite),     64'd0);
        check("reset memRead",      64'(bus.memRead),      64'd0);
        check("reset memAddress",   64'(bus.memAddress),   64'd0);
        check("reset memWriteData", 64'(bus.memWriteData), 64'd0);
        check("reset rdata0",       64'(bus.rdata0),       64'd0);
        check("reset rdata1",       64'(bus.rdata1),       64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_xfer(i, vecs[i]);

        // Reset in the middle of an ACCESS write: strobe must drop without a clock edge.
        set_port(1'b0, 1'b1, 1'b1, 32'h10, 32'h55AA55AA);
        step_check("rstmid access", 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid memWrite",     64'(bus.memWrite),     64'd0);
        check("rstmid memRead",      64'(bus.memRead),      64'd0);
        check("rstmid ack0",         64'(bus.ack0),         64'd0);
        check("rstmid memAddress",   64'(bus.memAddress),   64'd0);
        check("rstmid memWriteData", 64'(bus.memWriteData), 64'd0);
        check("rstmid rdata0",       64'(bus.rdata0),       64'd0);
        check("rstmid rdata1",       64'(bus.rdata1),       64'd0);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        step_check("rstmid held", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step_check("rstmid after", 1'b0, 1'b0, 1'b0, 1'b0);
        step_check("rstmid no ack", 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous first requests after reset: port 0 first, then port 1.
        set_port(1'b0, 1'b1, 1'b0, 32'h08, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'h0C, '0);
        step_check("tie p0 access", 1'b0, 1'b0, 1'b1, 1'b0);
        check("tie p0 memAddress", 64'(bus.memAddress), 64'h08);
        step_check("tie p0 resp", 1'b1, 1'b0, 1'b0, 1'b0);
        check("tie rdata0", 64'(bus.rdata0), 64'hC0DE0008);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        step_check("tie idle", 1'b0, 1'b0, 1'b0, 1'b0);
        step_check("tie p1 access", 1'b0, 1'b0, 1'b1, 1'b0);
        check("tie p1 memAddress", 64'(bus.memAddress), 64'h0C);
        step_check("tie p1 resp", 1'b0, 1'b1, 1'b0, 1'b0);
        check("tie rdata1", 64'(bus.rdata1), 64'hC0DE000C);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        step_check("tie end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous contention for 12 cycles; port 1 won the last grant.
        set_port(1'b0, 1'b1, 1'b0, 32'h08, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'h0C, '0);
        for (int i = 1; i <= 12; i++) begin
            bit is_resp;
            bit p1_turn;
            is_resp = (i % 3 == 2);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            p1_turn = 1'b0;
`else
            p1_turn = ((i / 3) % 2 == 1);
`endif
            step_check($sformatf("cont c%0d", i), is_resp && !p1_turn, is_resp && p1_turn,
                       (i % 3 == 1), 1'b0);
        end
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);

        // Late request: req1 rises during port 0's ACCESS and waits for the next IDLE.
        set_port(1'b0, 1'b1, 1'b1, 32'h30, 32'h77);
        step_check("late p0 access", 1'b0, 1'b0, 1'b0, 1'b1);
        set_port(1'b1, 1'b1, 1'b0, 32'h20, '0);
        step_check("late p0 resp", 1'b1, 1'b0, 1'b0, 1'b0);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        step_check("late idle", 1'b0, 1'b0, 1'b0, 1'b0);
        step_check("late p1 access", 1'b0, 1'b0, 1'b1, 1'b0);
        check("late p1 memAddress", 64'(bus.memAddress), 64'h20);
        step_check("late p1 resp", 1'b0, 1'b1, 1'b0, 1'b0);
        check("late rdata1", 64'(bus.rdata1), 64'h12345678);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        step_check("late end", 1'b0, 1'b0, 1'b0, 1'b0);
        check("late write landed", 64'(mem[12]), 64'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
